// File: rtl/det3_iter.sv
// det3_iter: iterative exact signed determinant of a 3x3 matrix (i_mode=0)
// or of its top-left 2x2 sub-matrix (i_mode=1).
// One shared W x (2W+1) signed multiplier and one OUT_W accumulator are
// time-multiplexed over the steps of the computation.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   i_valid  input matrix valid          i_ready  block can accept a matrix
//   i_mode   0 = 3x3, 1 = 2x2            i_array  [row][col] signed W entries
//   o_valid  result valid                o_ready  downstream accepts result
//   o_det    signed exact determinant    o_zero   o_det == 0 (with o_valid)
//
// Schedule: 3x3 = 6 cofactor steps (ei, fh, fg, di, dh, eg) + 3 accumulate
// steps (a*c0, b*c1, c*c2); 2x2 = 2 accumulate steps (+a*e, -b*d).
module det3_iter #(
  parameter int W     = 32,
  parameter int OUT_W = 3*W+2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic                    i_mode,
  input  logic signed [W-1:0]     i_array [2:0][2:0],
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic signed [OUT_W-1:0] o_det,
  output logic                    o_zero
);

  typedef enum logic [1:0] {IDLE, COF, ACC, DONE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              step_q, step_d;
  logic                    mode_q, mode_d;
  logic signed [W-1:0]     arr_q [2:0][2:0];
  logic signed [W-1:0]     arr_d [2:0][2:0];
  logic signed [2*W-1:0]   prev_q, prev_d;      // first product of a cofactor pair
  logic signed [2*W:0]     cof_q [3];
  logic signed [2*W:0]     cof_d [3];
  logic signed [OUT_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] det_q, det_d;
  logic                    zero_q, zero_d;
  logic                    i_ready_q, i_ready_d;
  logic                    o_valid_q, o_valid_d;

  // Shared multiplier operands and derived values
  logic signed [W-1:0]     op_a, op_b_ent;
  logic signed [2*W:0]     op_b, cof_sel;
  logic                    use_cof;
  logic [3*W:0]            mul_a_ext, mul_b_ext, prod;
  logic signed [2*W-1:0]   pair;
  logic signed [2*W:0]     cof_new;
  logic signed [OUT_W-1:0] term, sum;
  logic                    last_acc;

  // Operand selection for the current step
  always_comb begin
    op_a     = arr_q[0][0];
    op_b_ent = arr_q[1][1];
    cof_sel  = cof_q[0];
    use_cof  = 1'b0;
    case (state_q)
      COF: begin
        case (step_q)
          3'd0:    begin op_a = arr_q[1][1]; op_b_ent = arr_q[2][2]; end // e*i
          3'd1:    begin op_a = arr_q[1][2]; op_b_ent = arr_q[2][1]; end // f*h
          3'd2:    begin op_a = arr_q[1][2]; op_b_ent = arr_q[2][0]; end // f*g
          3'd3:    begin op_a = arr_q[1][0]; op_b_ent = arr_q[2][2]; end // d*i
          3'd4:    begin op_a = arr_q[1][0]; op_b_ent = arr_q[2][1]; end // d*h
          default: begin op_a = arr_q[1][1]; op_b_ent = arr_q[2][0]; end // e*g
        endcase
      end
      ACC: begin
        if (mode_q) begin
          if (step_q[0]) begin op_a = arr_q[0][1]; op_b_ent = arr_q[1][0]; end // b*d
          else           begin op_a = arr_q[0][0]; op_b_ent = arr_q[1][1]; end // a*e
        end else begin
          use_cof = 1'b1;
          case (step_q[1:0])
            2'd0:    begin op_a = arr_q[0][0]; cof_sel = cof_q[0]; end
            2'd1:    begin op_a = arr_q[0][1]; cof_sel = cof_q[1]; end
            default: begin op_a = arr_q[0][2]; cof_sel = cof_q[2]; end
          endcase
        end
      end
      default: ;
    endcase
    op_b = use_cof ? cof_sel : {{(W+1){op_b_ent[W-1]}}, op_b_ent};
  end

  // Both operands sign-extended to the full product width: the low 3W+1
  // bits of the unsigned product are then the exact signed product.
  assign mul_a_ext = {{(2*W+1){op_a[W-1]}}, op_a};
  assign mul_b_ext = {{W{op_b[2*W]}}, op_b};
  assign prod      = mul_a_ext * mul_b_ext;
  assign pair      = prod[2*W-1:0];
  assign cof_new   = {prev_q[2*W-1], prev_q} - {pair[2*W-1], pair};
  assign term      = {prod[3*W], prod};

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    mode_d    = mode_q;
    arr_d     = arr_q;
    prev_d    = prev_q;
    cof_d     = cof_q;
    acc_d     = acc_q;
    det_d     = det_q;
    zero_d    = zero_q;
    i_ready_d = i_ready_q;
    o_valid_d = o_valid_q;
    sum       = '0;
    last_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid && i_ready_q) begin
          arr_d     = i_array;
          mode_d    = i_mode;
          step_d    = 3'd0;
          acc_d     = '0;
          i_ready_d = 1'b0;
          state_d   = i_mode ? ACC : COF;
        end
      end
      COF: begin
        // Even steps hold the first product; odd steps close a cofactor.
        if (!step_q[0]) prev_d = pair;
        else            cof_d[step_q[2:1]] = cof_new;
        if (step_q == 3'd5) begin
          step_d  = 3'd0;
          state_d = ACC;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      ACC: begin
        sum      = (mode_q && step_q[0]) ? acc_q - term : acc_q + term;
        acc_d    = sum;
        last_acc = mode_q ? (step_q == 3'd1) : (step_q == 3'd2);
        if (last_acc) begin
          det_d     = sum;
          zero_d    = (sum == '0);
          o_valid_d = 1'b1;
          step_d    = 3'd0;
          state_d   = DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE: begin
        if (o_ready) begin
          o_valid_d = 1'b0;
          i_ready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      step_q    <= 3'd0;
      mode_q    <= 1'b0;
      prev_q    <= '0;
      acc_q     <= '0;
      det_q     <= '0;
      zero_q    <= 1'b0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        cof_q[r] <= '0;
        for (int c = 0; c < 3; c++) arr_q[r][c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      arr_q     <= arr_d;
      prev_q    <= prev_d;
      cof_q     <= cof_d;
      acc_q     <= acc_d;
      det_q     <= det_d;
      zero_q    <= zero_d;
      i_ready_q <= i_ready_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign o_det   = det_q;
  assign o_zero  = zero_q;

endmodule

// File: tb/tb_det3_iter.sv
// Testbench for det3_iter: directed matrices with hand-computed results on a
// W=32 and a W=8 instance. Expected results are queued at acceptance and a
// monitor compares them whenever the DUT presents o_valid.
module tb_det3_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // W = 32 instance
  logic               rst32, iv32, ir32, mode32, ov32, ordy32, oz32;
  logic signed [31:0] a32 [2:0][2:0];
  logic signed [97:0] od32;
  // W = 8 instance
  logic               rst8, iv8, ir8, mode8, ov8, ordy8, oz8;
  logic signed [7:0]  a8 [2:0][2:0];
  logic signed [25:0] od8;

  det3_iter #(.W(32)) dut32 (
    .clk(clk), .reset(rst32), .i_valid(iv32), .i_ready(ir32), .i_mode(mode32),
    .i_array(a32), .o_valid(ov32), .o_ready(ordy32), .o_det(od32), .o_zero(oz32)
  );

  det3_iter #(.W(8)) dut8 (
    .clk(clk), .reset(rst8), .i_valid(iv8), .i_ready(ir8), .i_mode(mode8),
    .i_array(a8), .o_valid(ov8), .o_ready(ordy8), .o_det(od8), .o_zero(oz8)
  );

  typedef struct {
    logic signed [97:0] det;
    logic               zero;
    int                 lat;
    int                 acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   vec [9];
  bit   seen [2];
  int   wait_cnt [2];

  task automatic check(input string name, input logic signed [97:0] act,
                       input logic signed [97:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int sel, input logic mode);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (sel == 0) a32[r][c] = vec[r*3+c];
        else          a8[r][c]  = 8'(vec[r*3+c]);
    if (sel == 0) begin mode32 = mode; iv32 = 1'b1; end
    else          begin mode8  = mode; iv8  = 1'b1; end
  endtask

  // Offer vec until accepted; afterwards scramble the inputs so a design
  // that fails to capture them produces a wrong result.
  task automatic send(input int sel, input logic mode, input logic signed [97:0] det,
                      input logic zero, input bit push, output int acc);
    int   n = 0;
    exp_t e;
    drive(sel, mode);
    while (!(sel == 0 ? ir32 : ir8) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: i_ready low for %0d cycles, expected high", n);
    end
    @(posedge clk); #1;
    acc = cyc;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a32[r][c] = $urandom;
        a8[r][c]  = 8'($urandom);
      end
    if (sel == 0) begin iv32 = 1'b0; mode32 = ~mode; end
    else          begin iv8  = 1'b0; mode8  = ~mode; end
    e = '{det: det, zero: zero, lat: (mode ? 2 : 9), acc: acc};
    if (push) begin
      if (sel == 0) q32.push_back(e);
      else          q8.push_back(e);
    end
  endtask

  task automatic monitor_dut(input int sel);
    logic               v, rdy, ir, z, rst;
    logic signed [97:0] d;
    int                 qn;
    exp_t               e;
    if (sel == 0) begin
      v = ov32; rdy = ordy32; ir = ir32; z = oz32; d = od32; rst = rst32; qn = q32.size();
      if (qn > 0) e = q32[0];
    end else begin
      v = ov8; rdy = ordy8; ir = ir8; z = oz8; d = od8; rst = rst8; qn = q8.size();
      if (qn > 0) e = q8[0];
    end
    if (rst) begin
      seen[sel] = 1'b0; wait_cnt[sel] = 0;
    end else if (v) begin
      wait_cnt[sel] = 0;
      if (qn == 0) begin
        check($sformatf("spurious_valid_%0d", sel), v, 0);
      end else begin
        if (!seen[sel]) begin
          check($sformatf("latency_%0d", sel), cyc - e.acc, e.lat);
          seen[sel] = 1'b1;
        end
        check($sformatf("det_%0d", sel), d, e.det);
        check($sformatf("zero_%0d", sel), z, e.zero);
        check($sformatf("i_ready_busy_%0d", sel), ir, 0);
        if (rdy) begin
          $display("txn dut%0d: det=%0d zero=%0d (expected %0d/%0d)", sel, d, z, e.det, e.zero);
          seen[sel] = 1'b0;
          if (sel == 0) void'(q32.pop_front());
          else          void'(q8.pop_front());
        end
      end
    end else if (qn > 0) begin
      wait_cnt[sel]++;
      if (wait_cnt[sel] > 40) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout_%0d: no o_valid in %0d cycles, expected det %0d", sel, wait_cnt[sel], e.det);
        wait_cnt[sel] = 0;
        if (sel == 0) void'(q32.pop_front());
        else          void'(q8.pop_front());
      end
    end
  endtask

  initial begin
    int acc, h, n;
    rst32 = 1'b1; rst8 = 1'b1; iv32 = 1'b0; iv8 = 1'b0;
    mode32 = 1'b0; mode8 = 1'b0; ordy32 = 1'b1; ordy8 = 1'b1;
    vec = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(0, 1'b0); drive(1, 1'b0); iv32 = 1'b0; iv8 = 1'b0;
    fork
      forever begin
        @(negedge clk);
        monitor_dut(0);
        monitor_dut(1);
      end
    join_none

    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    check("rst_i_ready32", ir32, 1); check("rst_o_valid32", ov32, 0);
    check("rst_o_det32", od32, 0);   check("rst_o_zero32", oz32, 0);
    check("rst_i_ready8", ir8, 1);   check("rst_o_valid8", ov8, 0);
    check("rst_o_det8", od8, 0);     check("rst_o_zero8", oz8, 0);
    rst32 = 1'b0; rst8 = 1'b0;
    @(posedge clk); #1;

    // Directed 3x3 / 2x2 vectors, W = 32
    vec = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    send(0, 1'b0, 1, 1'b0, 1'b1, acc);
    vec = '{6, 1, 1, 4, -2, 5, 2, 8, 7};
    send(0, 1'b0, -306, 1'b0, 1'b1, acc);
    vec = '{2, 0, 1, 1, 3, 2, 1, 1, 1};
    send(0, 1'b0, 0, 1'b1, 1'b1, acc);
    vec = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
    send(0, 1'b0, -3, 1'b0, 1'b1, acc);
    // 2x2 at the range limits: a=e=d=-2^31, b=2^31-1 -> 2^63 - 2^31
    vec = '{int'(32'h8000_0000), 2147483647, 77, int'(32'h8000_0000),
            int'(32'h8000_0000), 5, 9, 9, 9};
    send(0, 1'b1, 98'sd9223372034707292160, 1'b0, 1'b1, acc);

    // W = 8 extremes and a 2x2 with arbitrary outer entries
    vec = '{-128, -128, 0, 0, -128, -128, -128, 0, -128};
    send(1, 1'b0, -4194304, 1'b0, 1'b1, acc);
    vec = '{3, 4, 99, 5, 6, -7, 1, 2, 3};
    send(1, 1'b1, -2, 1'b0, 1'b1, acc);

    // Downstream stall in DONE with a new matrix waiting
    ordy32 = 1'b0;
    vec = '{6, 1, 1, 4, -2, 5, 2, 8, 7};
    send(0, 1'b0, -306, 1'b0, 1'b1, acc);
    n = 0;
    while (!ov32 && n < 40) begin @(posedge clk); #1; n++; end
    vec = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    drive(0, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    ordy32 = 1'b1;
    @(posedge clk); #1;
    h = cyc;
    send(0, 1'b0, 1, 1'b0, 1'b1, acc);
    check("accept_after_handshake", acc, h + 1);

    // Reset during COF step 4: the in-flight matrix must vanish
    repeat (12) begin @(posedge clk); #1; end
    vec = '{6, 1, 1, 4, -2, 5, 2, 8, 7};
    send(0, 1'b0, 0, 1'b0, 1'b0, acc);
    repeat (4) begin @(posedge clk); #1; end
    rst32 = 1'b1;
    @(posedge clk); #1;
    rst32 = 1'b0;
    check("i_ready_after_abort", ir32, 1);
    repeat (15) begin
      @(posedge clk); #1;
      check("no_valid_after_abort", ov32, 0);
    end
    vec = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    send(0, 1'b0, 1, 1'b0, 1'b1, acc);
    repeat (12) begin @(posedge clk); #1; end

    // Reset coinciding with an offered matrix: not accepted
    vec = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    drive(0, 1'b0);
    rst32 = 1'b1;
    @(posedge clk); #1;
    rst32 = 1'b0; iv32 = 1'b0;
    check("i_ready_after_rst_hs", ir32, 1);
    repeat (12) begin
      @(posedge clk); #1;
      check("no_valid_after_rst_hs", ov32, 0);
    end
    vec = '{3, 4, 11, 5, 6, 12, 13, 14, 15};
    send(0, 1'b1, -2, 1'b0, 1'b1, acc);

    repeat (30) begin @(posedge clk); #1; end
    check("q32_drained", q32.size(), 0);
    check("q8_drained", q8.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
